// File: rtl/uart_rx_ctrl_if.sv
// Bundle between the UART receive controller and its line input, config and sampler/deserializer pair.
// The master side drives line/config/sampled bit; the slave side is the controller, which returns strobes and status.
`timescale 1ns/1ps
interface uart_rx_ctrl_if #(parameter int PRESC_W = 6) ();
    logic               rx_in;
    logic [PRESC_W-1:0] prescale;
    logic               par_en;
    logic               par_typ;
    logic               sampled_bit;
    logic               dat_samp_en;
    logic               deser_en;
    logic               data_valid;
    logic               par_err;
    logic               stp_err;
    logic               busy;

    modport master (
        output rx_in, prescale, par_en, par_typ, sampled_bit,
        input  dat_samp_en, deser_en, data_valid, par_err, stp_err, busy
    );

    modport slave (
        input  rx_in, prescale, par_en, par_typ, sampled_bit,
        output dat_samp_en, deser_en, data_valid, par_err, stp_err, busy
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: strobes the sampler and deserializer, checks start/parity/stop.
// data_valid/errors appear one cycle after the stop-bit check point; no backpressure, the line cannot be stalled.
`timescale 1ns/1ps
module uart_rx_ctrl #(
    parameter int DATA_BITS = 8,
    parameter int PRESC_W   = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_rx_ctrl_if.slave  bus
);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t             state_q, state_d;
    logic [PRESC_W-1:0] edge_q, edge_d;
    logic [PRESC_W-1:0] p_q, p_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic               pe_q, pe_d, pt_q, pt_d;
    logic               acc_q, acc_d;
    logic               par_fail_q, par_fail_d;
    logic               par_err_q, par_err_d;
    logic               stp_err_q, stp_err_d;
    logic               dv_q, dv_d;
    logic               cp, bit_end;
    logic               deser_en;

    assign cp      = (edge_q == (p_q >> 1) + PRESC_W'(2));
    assign bit_end = (edge_q == p_q - PRESC_W'(1));

    always_comb begin
        state_d    = state_q;
        edge_d     = bit_end ? '0 : edge_q + PRESC_W'(1);
        p_d        = p_q;
        bit_d      = bit_q;
        pe_d       = pe_q;
        pt_d       = pt_q;
        acc_d      = acc_q;
        par_fail_d = par_fail_q;
        par_err_d  = par_err_q;
        stp_err_d  = stp_err_q;
        dv_d       = 1'b0;
        deser_en   = 1'b0;
        case (state_q)
            IDLE: begin
                edge_d = '0;
                if (!bus.rx_in) begin
                    state_d   = START;
                    p_d       = bus.prescale;
                    pe_d      = bus.par_en;
                    pt_d      = bus.par_typ;
                    par_err_d = 1'b0;
                    stp_err_d = 1'b0;
                end
            end
            START: begin
                if (cp && bus.sampled_bit) begin
                    state_d = IDLE;
                    edge_d  = '0;
                end else if (bit_end) begin
                    state_d    = DATA;
                    bit_d      = '0;
                    acc_d      = 1'b0;
                    par_fail_d = 1'b0;
                end
            end
            DATA: begin
                if (cp) begin
                    deser_en = 1'b1;
                    acc_d    = acc_q ^ bus.sampled_bit;
                end
                if (bit_end) begin
                    if (bit_q == BW'(DATA_BITS - 1)) state_d = pe_q ? PARITY : STOP;
                    else                             bit_d   = bit_q + BW'(1);
                end
            end
            PARITY: begin
                if (cp)      par_fail_d = bus.sampled_bit ^ acc_q ^ pt_q;
                if (bit_end) state_d    = STOP;
            end
            STOP: begin
                // Leave at the check point so a start bit right after the stop bit is not missed.
                if (cp) begin
                    stp_err_d = ~bus.sampled_bit;
                    par_err_d = par_fail_q;
                    dv_d      = ~(par_fail_q | ~bus.sampled_bit);
                    state_d   = IDLE;
                    edge_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                edge_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            edge_q     <= '0;
            p_q        <= '0;
            bit_q      <= '0;
            pe_q       <= 1'b0;
            pt_q       <= 1'b0;
            acc_q      <= 1'b0;
            par_fail_q <= 1'b0;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
            dv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_q     <= edge_d;
            p_q        <= p_d;
            bit_q      <= bit_d;
            pe_q       <= pe_d;
            pt_q       <= pt_d;
            acc_q      <= acc_d;
            par_fail_q <= par_fail_d;
            par_err_q  <= par_err_d;
            stp_err_q  <= stp_err_d;
            dv_q       <= dv_d;
        end
    end

    assign bus.dat_samp_en = (state_q != IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.deser_en    = deser_en;
    assign bus.data_valid  = dv_q;
    assign bus.par_err     = par_err_q;
    assign bus.stp_err     = stp_err_q;
endmodule
